// File: rtl/fp_addsub_ctrl_pkg.sv
// Shared types and constants for the FP add/subtract controller and its datapath.
package addpkg;

  localparam int FP_W  = 32;
  localparam int EXP_W = 8;
  localparam int SIG_W = 23;

  // Largest legal multicycle hold window for the datapath inputs.
  localparam int EXEC_CYCLES_MAX = 15;

  // Datapath error code layout (err_o bit positions).
  localparam int ERR_W        = 3;
  localparam int ERR_INVALID  = 0;
  localparam int ERR_OVERFLOW = 1;
  localparam int ERR_INEXACT  = 2;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} addsub_ctrl_state_t;

  // Leading-zero count over a 27-bit field whose MSB is the hidden-bit position.
  // Returns 27 for an all-zero field.
  function automatic logic [4:0] lead_zeros27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fp_addsub_ctrl_add_sub_top.sv
// Combinational IEEE-754 single-precision add/subtract datapath.
// Round-to-nearest-even, three guard bits (G, R, sticky), subnormals supported.
// err_o: bit 0 invalid, bit 1 overflow, bit 2 inexact.
module add_sub_top
  import addpkg::*;
(
  input  logic             sign1,
  input  logic [EXP_W-1:0] exp1,
  input  logic [SIG_W-1:0] sig1,
  input  logic             sign2,
  input  logic [EXP_W-1:0] exp2,
  input  logic [SIG_W-1:0] sig2,
  input  logic             op,
  output logic [FP_W-1:0]  fp_out,
  output logic [ERR_W-1:0] err_o
);

  logic        sign2_eff;
  logic        swap;
  logic        eff_sub;
  logic        sign_l;
  logic        sign_res;
  logic [7:0]  exp_l_raw;
  logic [7:0]  exp_s_raw;
  logic [22:0] sig_l;
  logic [22:0] sig_s;
  logic [7:0]  exp_l;
  logic [7:0]  exp_s;
  logic [23:0] man_l;
  logic [23:0] man_s;
  logic [7:0]  exp_diff;
  logic [27:0] ext_l;
  logic [27:0] ext_s_full;
  logic [27:0] ext_s;
  logic [27:0] lost_mask;
  logic [27:0] sum;
  logic [26:0] norm;
  logic [8:0]  exp_n;
  logic [4:0]  lz;
  logic [7:0]  shift_lim;
  logic [7:0]  shamt;
  logic        guard;
  logic        rest;
  logic        round_up;
  logic        inexact;
  logic        overflow;
  logic [31:0] rounded;
  logic        nan1;
  logic        nan2;
  logic        inf1;
  logic        inf2;
  logic        snan;

  // Align, add or subtract magnitudes, normalise, round, then override for NaN/Inf.
  always_comb begin
    sign2_eff  = sign2 ^ op;
    swap       = {exp2, sig2} > {exp1, sig1};
    eff_sub    = sign1 ^ sign2_eff;
    sign_l     = sign1;
    exp_l_raw  = exp1;
    sig_l      = sig1;
    exp_s_raw  = exp2;
    sig_s      = sig2;
    lost_mask  = '0;
    ext_s      = '0;
    sum        = '0;
    norm       = '0;
    exp_n      = '0;
    lz         = '0;
    shift_lim  = '0;
    shamt      = '0;
    fp_out     = '0;
    err_o      = '0;

    if (swap) begin
      sign_l    = sign2_eff;
      exp_l_raw = exp2;
      sig_l     = sig2;
      exp_s_raw = exp1;
      sig_s     = sig1;
    end

    // Subnormals use exponent 1 with no hidden bit.
    exp_l = (exp_l_raw == 8'd0) ? 8'd1 : exp_l_raw;
    exp_s = (exp_s_raw == 8'd0) ? 8'd1 : exp_s_raw;
    man_l = {exp_l_raw != 8'd0, sig_l};
    man_s = {exp_s_raw != 8'd0, sig_s};

    exp_diff   = exp_l - exp_s;
    ext_l      = {1'b0, man_l, 3'b000};
    ext_s_full = {1'b0, man_s, 3'b000};

    if (exp_diff >= 8'd27) begin
      ext_s = {27'd0, |man_s};
    end else begin
      lost_mask = (28'd1 << exp_diff) - 28'd1;
      ext_s     = (ext_s_full >> exp_diff) | {27'd0, |(ext_s_full & lost_mask)};
    end

    if (!eff_sub) begin
      sum = ext_l + ext_s;
      if (sum[27]) begin
        norm  = sum[27:1] | {26'd0, sum[0]};
        exp_n = {1'b0, exp_l} + 9'd1;
      end else begin
        norm  = sum[26:0];
        exp_n = {1'b0, exp_l};
      end
    end else begin
      sum       = ext_l - ext_s;
      lz        = lead_zeros27(sum[26:0]);
      shift_lim = exp_l - 8'd1;
      shamt     = ({3'b000, lz} > shift_lim) ? shift_lim : {3'b000, lz};
      norm      = sum[26:0] << shamt;
      exp_n     = {1'b0, exp_l} - {1'b0, shamt};
    end

    if (!norm[26]) exp_n = 9'd0;

    // An exact cancellation yields +0 under round-to-nearest.
    sign_res = (eff_sub && (sum == 28'd0)) ? 1'b0 : sign_l;

    guard    = norm[2];
    rest     = |norm[1:0];
    round_up = guard & (rest | norm[3]);
    rounded  = {exp_n, norm[25:3]} + 32'(round_up);
    overflow = rounded[31:23] >= 9'd255;
    inexact  = guard | rest | overflow;

    if (overflow) begin
      fp_out = {sign_l, 8'hFF, 23'd0};
    end else begin
      fp_out = {sign_res, rounded[30:0]};
    end
    err_o[ERR_OVERFLOW] = overflow;
    err_o[ERR_INEXACT]  = inexact;

    nan1 = (exp1 == 8'hFF) && (sig1 != 23'd0);
    nan2 = (exp2 == 8'hFF) && (sig2 != 23'd0);
    inf1 = (exp1 == 8'hFF) && (sig1 == 23'd0);
    inf2 = (exp2 == 8'hFF) && (sig2 == 23'd0);
    snan = (nan1 && !sig1[22]) || (nan2 && !sig2[22]);

    if (nan1 || nan2) begin
      fp_out = 32'h7FC0_0000;
      err_o  = '0;
      err_o[ERR_INVALID] = snan;
    end else if (inf1 && inf2 && eff_sub) begin
      fp_out = 32'h7FC0_0000;
      err_o  = '0;
      err_o[ERR_INVALID] = 1'b1;
    end else if (inf1) begin
      fp_out = {sign1, 8'hFF, 23'd0};
      err_o  = '0;
    end else if (inf2) begin
      fp_out = {sign2_eff, 8'hFF, 23'd0};
      err_o  = '0;
    end
  end

endmodule

// File: rtl/fp_addsub_ctrl.sv
// Round-robin arbiter and sequencer for one shared FP add/subtract datapath.
// Registers the winning operands, holds them for EXEC_CYCLES, captures the
// result and returns it on a valid/ready channel tagged with the requester ID.
module fp_addsub_ctrl
  import addpkg::*;
#(
  parameter int EXEC_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_opcode,
  input  logic [1:0][31:0] req_a,
  input  logic [1:0][31:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [31:0]      resp_result,
  output logic [2:0]       resp_err,
  output logic             busy
);

  generate
    if (EXEC_CYCLES < 1 || EXEC_CYCLES > EXEC_CYCLES_MAX) begin : g_bad_exec_cycles
      $error("fp_addsub_ctrl: EXEC_CYCLES must be within 1..15");
    end
  endgenerate

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  addsub_ctrl_state_t state;
  addsub_ctrl_state_t next_state;

  logic        rr_ptr;
  logic [3:0]  cnt;
  logic        op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        g_q;
  logic        grant;
  logic        req_fire;
  logic        resp_fire;
  logic        exec_done;
  logic [31:0] fp_out;
  logic [2:0]  err_o;

  // Grant: a lone requester always wins; a tie goes to rr_ptr.
  always_comb begin
    grant = req_valid[1];
    if (req_valid == 2'b11) grant = rr_ptr;
  end

  // Next-state logic, request accept and response handshake decode.
  always_comb begin
    next_state = state;
    req_ready  = 2'b00;
    req_fire   = 1'b0;
    resp_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          req_ready[grant] = 1'b1;
          req_fire         = 1'b1;
          next_state       = EXEC;
        end
      end
      EXEC: begin
        if (cnt == 4'd0) next_state = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_fire  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign exec_done  = (state == EXEC) && (cnt == 4'd0);
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Operand capture; only an accepted request may change these.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
      g_q  <= 1'b0;
    end else if (req_fire) begin
      op_q <= req_opcode[grant];
      a_q  <= req_a[grant];
      b_q  <= req_b[grant];
      g_q  <= grant;
    end
  end

  // Hold-window counter: loaded on accept, counts down to zero during EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (req_fire) begin
      cnt <= CNT_LOAD;
    end else if (state == EXEC && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Result capture at the end of the hold window; stable through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_result <= '0;
      resp_err    <= '0;
      resp_id     <= 1'b0;
    end else if (exec_done) begin
      resp_result <= fp_out;
      resp_err    <= err_o;
      resp_id     <= g_q;
    end
  end

  // Round-robin pointer moves to the other requester once a response retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         rr_ptr <= 1'b0;
    else if (resp_fire) rr_ptr <= ~g_q;
  end

  add_sub_top u_add_sub_top (
    .sign1  (a_q[31]),
    .exp1   (a_q[30:23]),
    .sig1   (a_q[22:0]),
    .sign2  (b_q[31]),
    .exp2   (b_q[30:23]),
    .sig2   (b_q[22:0]),
    .op     (op_q),
    .fp_out (fp_out),
    .err_o  (err_o)
  );

endmodule

// File: tb/tb_fp_addsub_ctrl.sv
// Directed self-checking bench for fp_addsub_ctrl (default and single-cycle hold).
module tb_fp_addsub_ctrl;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_opcode;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [31:0]      resp_result;
  logic [2:0]       resp_err;
  logic             busy;

  logic [1:0]       req_valid_1;
  logic [1:0]       req_ready_1;
  logic [1:0]       req_opcode_1;
  logic [1:0][31:0] req_a_1;
  logic [1:0][31:0] req_b_1;
  logic             resp_valid_1;
  logic             resp_ready_1;
  logic             resp_id_1;
  logic [31:0]      resp_result_1;
  logic [2:0]       resp_err_1;
  logic             busy_1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_result;
    logic [2:0]  exp_err;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  fp_addsub_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_opcode  (req_opcode),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_err    (resp_err),
    .busy        (busy)
  );

  fp_addsub_ctrl #(.EXEC_CYCLES(1)) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid_1),
    .req_ready   (req_ready_1),
    .req_opcode  (req_opcode_1),
    .req_a       (req_a_1),
    .req_b       (req_b_1),
    .resp_valid  (resp_valid_1),
    .resp_ready  (resp_ready_1),
    .resp_id     (resp_id_1),
    .resp_result (resp_result_1),
    .resp_err    (resp_err_1),
    .busy        (busy_1)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic waitResp(output int lat);
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input int id, input logic op, input logic [31:0] a,
                               input logic [31:0] b, output int lat);
    lat = -1;
    @(negedge clk);
    req_valid[id]  = 1'b1;
    req_opcode[id] = op;
    req_a[id]      = a;
    req_b[id]      = b;
    #1;
    for (int k = 0; k < 30 && !req_ready[id]; k++) begin
      @(negedge clk);
      #1;
    end
    if (!req_ready[id]) begin
      req_valid[id] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
    waitResp(lat);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          lat;
    int          got;
    logic        seen;
    logic        ids[4];
    logic [31:0] res[4];

    vecs[0]  = '{0, 1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 3'b000};
    vecs[1]  = '{1, 1'b1, 32'h40400000, 32'h3F800000, 32'h40000000, 3'b000};
    vecs[2]  = '{0, 1'b0, 32'h3FC00000, 32'h3FC00000, 32'h40400000, 3'b000};
    vecs[3]  = '{1, 1'b0, 32'h40A00000, 32'hC0400000, 32'h40000000, 3'b000};
    vecs[4]  = '{0, 1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, 3'b000};
    vecs[5]  = '{1, 1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b110};
    vecs[6]  = '{0, 1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 3'b100};
    vecs[7]  = '{1, 1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002, 3'b100};
    vecs[8]  = '{0, 1'b0, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3'b000};
    vecs[9]  = '{1, 1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 3'b001};
    vecs[10] = '{0, 1'b0, 32'h00000001, 32'h00000001, 32'h00000002, 3'b000};
    vecs[11] = '{1, 1'b0, 32'h40400000, 32'h80000000, 32'h40400000, 3'b000};

    req_valid    = '0;
    req_opcode   = '0;
    req_a        = '0;
    req_b        = '0;
    resp_ready   = 1'b0;
    req_valid_1  = '0;
    req_opcode_1 = '0;
    req_a_1      = '0;
    req_b_1      = '0;
    resp_ready_1 = 1'b1;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_resp_result", resp_result, 32'd0);
    checkOutput("reset_resp_err", 32'(resp_err), 32'd0);
    checkOutput("reset_resp_id", 32'(resp_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] table vectors");
    resp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, lat);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      checkOutput($sformatf("vec%0d_result", i), resp_result, vecs[i].exp_result);
      checkOutput($sformatf("vec%0d_err", i), 32'(resp_err), 32'(vecs[i].exp_err));
      checkOutput($sformatf("vec%0d_id", i), 32'(resp_id), 32'(vecs[i].id));
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_resp_one_cycle", i), 32'(resp_valid), 32'd0);
    end

    $display("[TB] round-robin arbitration");
    resetDut();
    @(negedge clk);
    req_opcode = 2'b00;
    req_a[0]   = 32'h3F800000;
    req_b[0]   = 32'h40000000;
    req_a[1]   = 32'h40000000;
    req_b[1]   = 32'h40000000;
    req_valid  = 2'b11;
    got = 0;
    for (int c = 0; c < 60 && got < 4; c++) begin
      @(posedge clk);
      #1;
      if (resp_valid) begin
        ids[got] = resp_id;
        res[got] = resp_result;
        got++;
        if (got == 4) req_valid = 2'b00;
      end
    end
    req_valid = 2'b00;
    checkOutput("rr_count", 32'(got), 32'd4);
    for (int k = 0; k < got; k++) begin
      checkOutput($sformatf("rr_id%0d", k), 32'(ids[k]), 32'(k % 2));
      checkOutput($sformatf("rr_result%0d", k), res[k],
                  (k % 2 == 1) ? 32'h40800000 : 32'h40400000);
    end
    @(posedge clk);
    #1;

    $display("[TB] response backpressure");
    resp_ready = 1'b0;
    applyStimulus(0, 1'b0, 32'h3F800000, 32'h40000000, lat);
    checkOutput("bp_latency", 32'(lat), 32'd2);
    @(negedge clk);
    req_valid[1]  = 1'b1;
    req_opcode[1] = 1'b1;
    req_a[1]      = 32'h40400000;
    req_b[1]      = 32'h3F800000;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput($sformatf("bp_valid%0d", k), 32'(resp_valid), 32'd1);
      checkOutput($sformatf("bp_result%0d", k), resp_result, 32'h40400000);
      checkOutput($sformatf("bp_req_ready%0d", k), 32'(req_ready), 32'd0);
      checkOutput($sformatf("bp_busy%0d", k), 32'(busy), 32'd1);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_released_valid", 32'(resp_valid), 32'd0);
    checkOutput("bp_next_ready", 32'(req_ready), 32'd2);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    waitResp(lat);
    checkOutput("bp_next_latency", 32'(lat), 32'd2);
    checkOutput("bp_next_result", resp_result, 32'h40000000);
    checkOutput("bp_next_id", 32'(resp_id), 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] reset during EXEC");
    resetDut();
    applyStimulus(0, 1'b0, 32'h3F800000, 32'h40000000, lat);
    checkOutput("abort_pre_result", resp_result, 32'h40400000);
    @(posedge clk);
    #1;
    @(negedge clk);
    req_valid[1]  = 1'b1;
    req_opcode[1] = 1'b0;
    req_a[1]      = 32'h40A00000;
    req_b[1]      = 32'hC0400000;
    #1;
    checkOutput("abort_accept_ready", 32'(req_ready), 32'd2);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    checkOutput("abort_busy_exec", 32'(busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy_reset", 32'(busy), 32'd0);
    checkOutput("abort_valid_reset", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen = 1'b1;
    end
    checkOutput("abort_no_response", 32'(seen), 32'd0);
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    checkOutput("abort_rr_ptr_cleared", 32'(req_ready), 32'd1);
    req_valid = 2'b00;
    applyStimulus(1, 1'b1, 32'h40400000, 32'h3F800000, lat);
    checkOutput("abort_after_latency", 32'(lat), 32'd2);
    checkOutput("abort_after_result", resp_result, 32'h40000000);
    checkOutput("abort_after_id", 32'(resp_id), 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] single-cycle hold window");
    @(negedge clk);
    req_valid_1[0]  = 1'b1;
    req_opcode_1[0] = 1'b0;
    req_a_1[0]      = 32'h3F800000;
    req_b_1[0]      = 32'h40000000;
    #1;
    checkOutput("ec1_req_ready", 32'(req_ready_1), 32'd1);
    @(posedge clk);
    #1;
    req_valid_1[0] = 1'b0;
    req_a_1[0]     = 32'h40A00000;
    req_b_1[0]     = 32'h40A00000;
    checkOutput("ec1_busy", 32'(busy_1), 32'd1);
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (resp_valid_1) begin
        lat = c;
        break;
      end
    end
    checkOutput("ec1_latency", 32'(lat), 32'd1);
    checkOutput("ec1_result", resp_result_1, 32'h40400000);
    checkOutput("ec1_err", 32'(resp_err_1), 32'd0);
    checkOutput("ec1_id", 32'(resp_id_1), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("ec1_idle_after", 32'(busy_1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_addsub_ctrl.md
# fp_addsub_ctrl

- Sequencing and arbitration controller for the shared floating-point add/subtract datapath, `add_sub_top`.
- Two independent requesters, such as the integer-issue and FP-issue ports of the RISC-V FPU, share one datapath instance.
- The block arbitrates round-robin, registers the winning operands, and holds them stable for a programmable multicycle window while the combinational datapath settles.
- It captures the result and error code, and returns them over a valid/ready response channel tagged with the requester ID.

## Interface
Parameters:
- `EXEC_CYCLES`, default 2: cycles the datapath inputs are held before the result is sampled. Legal range 1..15.

Ports:
- `clk` — in, 1: single clock; all state updates on the rising edge.
- `rst_n` — in, 1: asynchronous, active-low reset.
- `req_valid` — in, [1:0]: per-requester request valid.
- `req_ready` — out, [1:0]: per-requester accept; at most one bit high.
- `req_opcode` — in, [1:0]: per-requester op; 0 = add, 1 = subtract.
- `req_a` — in, [1:0][31:0]: per-requester operand A, IEEE-754 single precision.
- `req_b` — in, [1:0][31:0]: per-requester operand B, IEEE-754 single precision.
- `resp_valid` — out, 1: result available.
- `resp_ready` — in, 1: consumer accepts the result.
- `resp_id` — out, 1: requester that issued the result.
- `resp_result` — out, 32: packed single-precision result (`fp_out`).
- `resp_err` — out, 3: datapath error code (`err_o`), passed through unmodified.
- `busy` — out, 1: high whenever the state is not IDLE.

## Operation
The state machine has three states: IDLE, EXEC and RESP.

IDLE
- Grant is combinational from `req_valid` and `rr_ptr`:
  - If only one `req_valid` bit is set, that requester wins.
  - If both are set, requester `rr_ptr` wins.
- `req_ready[g]` = 1 for the winner only. Both bits are 0 when no request is pending.
- On handshake (`req_valid[g] & req_ready[g]` at an edge):
  - register `req_opcode[g]`, `req_a[g]`, `req_b[g]` and `g`;
  - load `cnt` = `EXEC_CYCLES`-1;
  - go to EXEC.

EXEC
- Datapath inputs come from the registered operands only:
  - `sign1` = `a[31]`, `exp1` = `a[30:23]`, `sig1` = `a[22:0]`;
  - likewise for operand B.
- `cnt` decrements each cycle.
- At the edge where `cnt` = 0:
  - capture `fp_out` into `resp_result` and `err_o` into `resp_err`;
  - set `resp_id` = `g`;
  - go to RESP.

RESP
- `resp_valid` = 1. `resp_result`, `resp_err` and `resp_id` hold stable until the handshake.
- On `resp_valid & resp_ready`:
  - `rr_ptr` ← ~`g`;
  - go to IDLE.

Other rules:
- `req_ready` = 2'b00 in EXEC and RESP. Requests presented then are ignored, not dropped; requesters must hold `req_valid` and the payload until accepted.
- Operand registers do not change outside the IDLE handshake. Changing `req_*` while in EXEC has no effect on the in-flight result.
- Arithmetic and rounding belong entirely to the datapath. This block performs no FP computation or width conversion.

## Timing
- Reset values (asynchronous assert, synchronous deassert by the reset network):
  - state = IDLE, `rr_ptr` = 0, `cnt` = 0;
  - operand registers = 0;
  - `resp_valid` = 0, `resp_result` = 0, `resp_err` = 0, `resp_id` = 0;
  - `busy` = 0, `req_ready` = 0 unless `req_valid` is asserted.
- Latency: a request accepted at edge E0 raises `resp_valid` after edge E0+`EXEC_CYCLES`.
- With `EXEC_CYCLES` = 1, EXEC lasts exactly one cycle.
- Minimum issue interval is `EXEC_CYCLES`+2 cycles: EXEC, then at least one RESP cycle, then one IDLE cycle.
- `resp_ready` held high gives RESP a duration of exactly one cycle.
- Back-to-back competing requests alternate strictly. A lone requester is served every interval regardless of `rr_ptr`.
- Reset mid-operation (EXEC or RESP) aborts the transaction: no response is issued and `rr_ptr` returns to 0.
- `resp_ready` asserted outside RESP is ignored.

## Structure
- Add to `addpkg`:
  - `typedef enum logic [1:0] {IDLE, EXEC, RESP} addsub_ctrl_state_t`;
  - localparams `FP_W` = 32, `EXP_W` = 8, `SIG_W` = 23;
  - the `EXEC_CYCLES` upper bound (15) as a localparam for checking.
- One sub-module, `add_sub_top`, instantiated as the shared datapath. The arbiter and FSM are inline.
- Elaboration-time check that `EXEC_CYCLES` is within 1..15.

## Test plan
1. Requester 0: add, A = 0x3F800000, B = 0x40000000, with `resp_ready` = 1 → `resp_valid` after 2 edges (default `EXEC_CYCLES`), `resp_result` = 0x40400000, `resp_err` = 0, `resp_id` = 0.
2. Requester 1: subtract, A = 0x40400000, B = 0x3F800000 → `resp_result` = 0x40000000, `resp_id` = 1.
3. Both requesters valid in the same cycle after reset, each issuing a different add → requester 0 is served first, then requester 1. Repeating the test yields the order 0, 1, 0, 1.
4. Hold `resp_ready` = 0 for 5 cycles during RESP → `resp_valid` and `resp_result` stay stable, `req_ready` stays 2'b00, and `busy` = 1. After release, the next request is accepted.
5. Assert `rst_n` low during EXEC → state returns to IDLE, `resp_valid` = 0, no response appears, and a subsequent request completes normally.
6. With `EXEC_CYCLES` = 1 → latency is 1 edge. Changing `req_a` during EXEC does not alter `resp_result`.
